// File: rtl/routing_pkg.sv
// Shared routing definitions: default demux geometry, select-width helper
// and the per-lane occupancy state.
package routing_pkg;

  localparam int DEMUX_WIDTH = 8;
  localparam int DEMUX_LANES = 4;

  // Ceiling log2, with a floor of 1 so a select field is never zero bits wide.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return (r < 1) ? 1 : r;
  endfunction

  typedef enum logic {
    LANE_EMPTY = 1'b0,
    LANE_FULL  = 1'b1
  } lane_state_t;

endpackage

// File: rtl/demux_lane_reg.sv
// Single-entry holding register with valid/ready. A load in the same
// cycle as a pop replaces the word, so the lane streams without bubbles.
module demux_lane_reg
  import routing_pkg::*;
#(
  parameter int WIDTH = DEMUX_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             ready,
  output logic             valid,
  output logic [WIDTH-1:0] data
);

  lane_state_t      state_q, state_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             pop;

  assign pop = (state_q == LANE_FULL) & ready;

  always_comb begin
    // NOTE: every output of this block is assigned a default first so no path infers a latch.
    state_d = state_q;
    data_d  = data_q;
    if (load) begin
      state_d = LANE_FULL;
      data_d  = load_data;
    end else if (pop) begin
      state_d = LANE_EMPTY;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= LANE_EMPTY;
      // NOTE: the data register is reset too, since out_data must read zero after reset.
      data_q  <= '0;
    end else begin
      // NOTE: non-blocking updates so every flop samples pre-edge values.
      state_q <= state_d;
      data_q  <= data_d;
    end
  end

  assign valid = (state_q == LANE_FULL);
  assign data  = data_q;

endmodule

// File: rtl/demux_stream_8bitx4.sv
// Registered 1-to-LANES stream demultiplexer with per-lane holding registers.
// Define DEMUX_STREAM_RR_SEL_EN to steer round-robin instead of by in_sel.
module demux_stream_8bitx4
  import routing_pkg::*;
#(
  parameter int WIDTH = DEMUX_WIDTH,
  parameter int LANES = DEMUX_LANES,
  parameter int SEL_W = clog2(LANES),
  parameter int CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [WIDTH-1:0]       in_data,
  input  logic [SEL_W-1:0]       in_sel,
  output logic [LANES-1:0]       out_valid,
  input  logic [LANES-1:0]       out_ready,
  output logic [LANES*WIDTH-1:0] out_data,
  output logic [CNT_W-1:0]       word_cnt
);

  logic [SEL_W-1:0] dest;
  logic             accept;
  logic [CNT_W-1:0] word_cnt_q, word_cnt_d;

`ifdef DEMUX_STREAM_RR_SEL_EN
  logic [SEL_W-1:0] ptr_q, ptr_d;
  logic             unused_sel;

  assign unused_sel = ^in_sel;
  assign dest       = ptr_q;

  // LANES is a power of two, so natural overflow gives the modulo wrap.
  always_comb begin
    ptr_d = ptr_q;
    if (accept) ptr_d = ptr_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr_q <= '0;
    else        ptr_q <= ptr_d;
  end
`else
  assign dest = in_sel;
`endif

  // Ready passes through the target lane's out_ready so a full lane being
  // popped this cycle can take the next word; forced low while in reset.
  assign in_ready = rst_n & (~out_valid[dest] | out_ready[dest]);
  assign accept   = in_valid & in_ready;

  always_comb begin
    word_cnt_d = word_cnt_q;
    if (accept) word_cnt_d = word_cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) word_cnt_q <= '0;
    else        word_cnt_q <= word_cnt_d;
  end

  assign word_cnt = word_cnt_q;

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    demux_lane_reg #(.WIDTH(WIDTH)) u_lane (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (accept && (dest == SEL_W'(k))),
      .load_data(in_data),
      .ready    (out_ready[k]),
      .valid    (out_valid[k]),
      .data     (out_data[k*WIDTH +: WIDTH])
    );
  end

endmodule

// File: tb/tb_demux_stream_8bitx4.sv
// Directed self-checking bench for demux_stream_8bitx4; the round-robin
// section is compiled when DEMUX_STREAM_RR_SEL_EN is defined.
module tb_demux_stream_8bitx4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_data;
  logic [1:0]  in_sel;
  logic [3:0]  out_valid;
  logic [3:0]  out_ready;
  logic [31:0] out_data;
  logic [15:0] word_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  demux_stream_8bitx4 dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .in_sel   (in_sel),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .word_cnt (word_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] lane(input int k);
    return out_data[k*8 +: 8];
  endfunction

  // Advance one edge and settle 1 ns past it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [1:0] sel, input logic [7:0] data);
    in_sel   = sel;
    in_data  = data;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
  endtask

  // Assert reset between edges and check the asynchronous clear.
  task automatic reset_mid();
    in_valid = 1'b1;
    in_sel   = 2'd1;
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_out_valid", 32'(out_valid), 32'h0);
    check("rst_word_cnt", 32'(word_cnt), 32'h0);
    check("rst_in_ready", 32'(in_ready), 32'h0);
    check("rst_out_data", out_data, 32'h0);
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    step();
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_sel    = '0;
    out_ready = '0;
    #1;
    check("init_in_ready", 32'(in_ready), 32'h0);
    check("init_out_valid", 32'(out_valid), 32'h0);
    check("init_word_cnt", 32'(word_cnt), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    step();

`ifndef DEMUX_STREAM_RR_SEL_EN
    // Basic steer to lane 2.
    in_sel = 2'd2; in_data = 8'hA5; in_valid = 1'b1;
    #1;
    check("steer_in_ready", 32'(in_ready), 32'h1);
    step();
    in_valid = 1'b0;
    check("steer_out_valid", 32'(out_valid), 32'h4);
    check("steer_lane2", 32'(lane(2)), 32'hA5);
    check("steer_word_cnt", 32'(word_cnt), 32'd1);

    // Backpressure on lane 0, then release with a same-cycle pop.
    send(2'd0, 8'h11);
    in_sel = 2'd0; in_data = 8'h3C; in_valid = 1'b1;
    #1;
    check("bp_in_ready_low", 32'(in_ready), 32'h0);
    step();
    check("bp_lane0_kept", 32'(lane(0)), 32'h11);
    check("bp_word_cnt", 32'(word_cnt), 32'd2);
    out_ready = 4'b0001;
    #1;
    check("bp_in_ready_pass", 32'(in_ready), 32'h1);
    step();
    in_valid = 1'b0; out_ready = 4'b0000;
    check("bp_lane0_new", 32'(lane(0)), 32'h3C);
    check("bp_out_valid", 32'(out_valid), 32'h5);
    check("bp_word_cnt2", 32'(word_cnt), 32'd3);

    out_ready = 4'b1111;
    step();
    out_ready = 4'b0000;
    check("drain_out_valid", 32'(out_valid), 32'h0);

    // Back-to-back throughput on lane 1 with a consumer always ready.
    out_ready = 4'b0010;
    in_sel    = 2'd1;
    in_valid  = 1'b1;
    for (int i = 0; i < 8; i++) begin
      in_data = 8'(i);
      #1;
      check("tp_in_ready", 32'(in_ready), 32'h1);
      step();
      check("tp_lane1", 32'(lane(1)), 32'(i));
      check("tp_valid1", 32'(out_valid[1]), 32'h1);
    end
    in_valid = 1'b0;
    check("tp_word_cnt", 32'(word_cnt), 32'd11);
    step();
    out_ready = 4'b0000;
    check("tp_drained", 32'(out_valid), 32'h0);

    // Lane independence: lane 3 stalled while other lanes fill.
    send(2'd3, 8'hEE);
    for (int k = 0; k < 3; k++) begin
      in_sel = 2'(k); in_data = 8'(8'h40 + k); in_valid = 1'b1;
      #1;
      check("ind_in_ready", 32'(in_ready), 32'h1);
      step();
      in_valid = 1'b0;
    end
    check("ind_out_valid", 32'(out_valid), 32'hF);
    check("ind_lane3", 32'(lane(3)), 32'hEE);
    check("ind_lanes012", {8'h0, lane(2), lane(1), lane(0)}, 32'h00424140);
    check("ind_word_cnt", 32'(word_cnt), 32'd15);
    in_sel = 2'd3; in_data = 8'h99; in_valid = 1'b1;
    #1;
    check("ind_lane3_blocked", 32'(in_ready), 32'h0);
    in_valid = 1'b0;

    // Leave lanes 1 and 3 full, then reset mid-stream.
    out_ready = 4'b0101;
    step();
    out_ready = 4'b0000;
    check("pre_rst_valid", 32'(out_valid), 32'hA);
    reset_mid();
`else
    // Fill all four lanes in rotation; in_sel is ignored.
    for (int i = 0; i < 4; i++) send(2'd0, 8'(8'hA0 + i));
    check("rr_fill_valid", 32'(out_valid), 32'hF);
    check("rr_fill_data", out_data, 32'hA3A2A1A0);
    out_ready = 4'b1011;
    step();
    check("rr_lane2_only", 32'(out_valid), 32'h4);
    send(2'd0, 8'hB0);
    check("rr_b0_lane0", 32'(lane(0)), 32'hB0);
    send(2'd0, 8'hB1);
    check("rr_b1_lane1", 32'(lane(1)), 32'hB1);
    in_sel = 2'd0; in_data = 8'hB2; in_valid = 1'b1;
    #1;
    check("rr_stall_ready", 32'(in_ready), 32'h0);
    step();
    check("rr_stall_lane2", 32'(lane(2)), 32'hA2);
    check("rr_stall_lane3", 32'(out_valid[3]), 32'h0);
    check("rr_stall_cnt", 32'(word_cnt), 32'd6);
    out_ready = 4'b1111;
    #1;
    check("rr_release_ready", 32'(in_ready), 32'h1);
    step();
    out_ready = 4'b0000;
    check("rr_b2_lane2", 32'(lane(2)), 32'hB2);
    check("rr_b2_lane3_empty", 32'(out_valid[3]), 32'h0);
    send(2'd0, 8'hB3);
    check("rr_b3_lane3", 32'(lane(3)), 32'hB3);
    check("rr_word_cnt", 32'(word_cnt), 32'd8);
    reset_mid();
`endif

    // Counter wrap: 65536 accepted words from reset return word_cnt to 0.
    out_ready = 4'b1111;
    in_sel    = 2'd0;
    in_valid  = 1'b1;
    for (int i = 0; i < 65535; i++) begin
      in_data = 8'(i);
      step();
    end
    check("wrap_max", 32'(word_cnt), 32'hFFFF);
    step();
    in_valid = 1'b0;
    check("wrap_zero", 32'(word_cnt), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
